pc_sequencer: RTL and testbench

- Fetch/next-PC controller for the MIPS processor. It owns the program-counter register and sequences instruction fetch over a req/ack instruction-memory handshake.
- It presents fetched instructions to decode and selects the next PC from redirect inputs: sequential, branch, jump, jump-register or exception.
- It also detects fetch timeouts and halts on request.

---
 rtl/pc_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS fetch / next-PC controller.
// Owns the PC register, sequences instruction fetch over a req/ack imem
// handshake, hands instructions to decode and selects the next PC.
// Optional build macro: BRANCH_DELAY_SLOT_EN (architectural branch delay slot).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_BOOT   | one idle cycle after reset release
// S_FETCH  | imem_req high, waiting for imem_ack, timeout counter running
// S_ISSUE  | instr_valid high, waiting for decode to accept (!stall)
// S_HALTED | halt accepted; no fetch until Reset
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned ACK_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        Reset,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    input  logic        halt,
    output logic        fetch_err,
    output logic [31:0] epc
);

    localparam int unsigned   CW       = $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   epc_q, epc_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

`ifdef BRANCH_DELAY_SLOT_EN
    logic          pend_q, pend_d;
    logic [31:0]   ptgt_q, ptgt_d;
`endif

    logic [31:0]   pc4;
    logic [31:0]   redir_tgt;
    logic          redir;
    logic          jr_bad;
    logic          take_exc;
    logic [31:0]   next_pc;

    // Redirect target candidates; priority jr > jump > branch.
    assign pc4       = pc_q + 32'd4;
    assign redir     = jr | jump | branch_taken;
    assign jr_bad    = jr & (jr_target[1:0] != 2'b00);
    assign redir_tgt = jr   ? jr_target :
                       jump ? {pc4[31:28], jump_index, 2'b00} :
                              pc4 + (branch_offset << 2);

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state_q <= S_BOOT;
        else        state_q <= state_d;
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        take_exc = 1'b0;
        next_pc  = pc4;
`ifdef BRANCH_DELAY_SLOT_EN
        pend_d   = pend_q;
        ptgt_d   = ptgt_q;
`endif
        case (state_q)
            S_BOOT: begin
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    // Timeout: retry the fetch from the exception vector.
                    err_d = 1'b1;
                    epc_d = pc_q;
                    pc_d  = EXC_VECTOR;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    valid_d = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
                    if (exc) begin
                        // In a delay slot the fault is reported at the branch.
                        take_exc = 1'b1;
                        epc_d    = pend_q ? (pc_q - 32'd4) : pc_q;
                        pend_d   = 1'b0;
                    end else if (pend_q) begin
                        next_pc = ptgt_q;
                        pend_d  = 1'b0;
                    end else if (jr_bad) begin
                        take_exc = 1'b1;
                        epc_d    = pc_q;
                    end else if (redir) begin
                        ptgt_d = redir_tgt;
                        pend_d = 1'b1;
                    end
`else
                    if (exc || jr_bad) begin
                        take_exc = 1'b1;
                        epc_d    = pc_q;
                    end else if (redir) begin
                        next_pc = redir_tgt;
                    end
`endif
                    pc_d    = take_exc ? EXC_VECTOR : next_pc;
                    state_d = (halt && !take_exc) ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: begin
            end
            default: state_d = S_BOOT;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= 32'd0;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_q  <= 1'b0;
            ptgt_q  <= 32'd0;
`endif
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == S_FETCH);
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;
    assign epc         = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized fetch
// latency / stall / redirect traffic checked against an instruction-level
// reference model.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h8000_0180;
    localparam int          AT = 16;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] pc, imem_addr, instr, epc;
    logic        imem_req, instr_valid, fetch_err;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0, exc = 1'b0, halt = 1'b0;
    logic [31:0] branch_offset = 32'd0, jr_target = 32'd0;
    logic [25:0] jump_index = 26'd0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EV), .ACK_TIMEOUT(AT)) dut (
        .clk(clk), .Reset(Reset), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
        .exc(exc), .halt(halt), .fetch_err(fetch_err), .epc(epc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (instruction level).
    logic [31:0] m_pc = RV, m_epc = 32'd0, m_instr = 32'd0, m_ptgt = 32'd0;
    bit          m_pend = 1'b0, m_halted = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_offset = 32'd0; jump = 1'b0;
        jump_index = 26'd0; jr = 1'b0; jr_target = 32'd0; exc = 1'b0; halt = 1'b0;
    endtask

    task automatic rand_redirect();
        int k;
        int off;
        k   = int'($urandom_range(0, 9));
        off = int'($urandom_range(0, 64)) - 32;
        clear_inputs();
        branch_offset = 32'(off);
        jump_index    = 26'($urandom);
        jr_target     = $urandom;
        case (k)
            1, 2: branch_taken = 1'b1;
            3:    jump = 1'b1;
            4:    begin jr = 1'b1; jr_target[1:0] = 2'b00; end
            5:    jr = 1'b1;
            6:    exc = 1'b1;
            7:    begin
                      branch_taken = 1'($urandom); jump = 1'($urandom);
                      jr = 1'($urandom); exc = 1'($urandom);
                  end
            default: ;
        endcase
    endtask

    // Next PC for the instruction at m_pc, from the current redirect inputs.
    task automatic model_accept();
        logic [31:0] pc4, tgt, nxt;
        bit          take_exc;
        pc4      = m_pc + 32'd4;
        nxt      = pc4;
        take_exc = 1'b0;
        if (jr)        tgt = jr_target;
        else if (jump) tgt = {pc4[31:28], jump_index, 2'b00};
        else           tgt = pc4 + branch_offset * 32'd4;
`ifdef BRANCH_DELAY_SLOT_EN
        if (exc) begin
            take_exc = 1'b1; m_epc = m_pend ? m_pc - 32'd4 : m_pc; m_pend = 1'b0;
        end else if (m_pend) begin
            nxt = m_ptgt; m_pend = 1'b0;
        end else if (jr && jr_target[1:0] != 2'b00) begin
            take_exc = 1'b1; m_epc = m_pc;
        end else if (jr || jump || branch_taken) begin
            m_ptgt = tgt; m_pend = 1'b1;
        end
`else
        if (exc || (jr && jr_target[1:0] != 2'b00)) begin
            take_exc = 1'b1; m_epc = m_pc;
        end else if (jr || jump || branch_taken) begin
            nxt = tgt;
        end
`endif
        m_pc     = take_exc ? EV : nxt;
        m_halted = halt && !take_exc;
    endtask

    // Entered and left at a negedge.
    task automatic do_reset();
        Reset = 1'b0;
        imem_ack = 1'($urandom);
        clear_inputs();
        #1;
        m_pc = RV; m_epc = 32'd0; m_instr = 32'd0; m_pend = 1'b0; m_ptgt = 32'd0; m_halted = 1'b0;
        check_eq("rst_pc", pc, RV);
        check_eq("rst_epc", epc, 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_err", 32'(fetch_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        check_eq("boot_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        check_eq("boot_fetch_req", 32'(imem_req), 32'd1);
        check_eq("boot_valid", 32'(instr_valid), 32'd0);
        check_eq("boot_pc", pc, RV);
    endtask

    // Hold ack low for 'delay' cycles, then ack with 'word'.
    task automatic fetch(input int delay, input logic [31:0] word);
        int waited;
        waited = 0;
        check_eq("fetch_req", 32'(imem_req), 32'd1);
        check_eq("fetch_addr", imem_addr, m_pc);
        check_eq("fetch_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            @(posedge clk);
            waited++;
            @(negedge clk);
            if (waited == AT) begin
                m_epc = m_pc; m_pc = EV; waited = 0;
                check_eq("timeout_err", 32'(fetch_err), 32'd1);
                check_eq("timeout_epc", epc, m_epc);
            end else begin
                check_eq("wait_err", 32'(fetch_err), 32'd0);
            end
            check_eq("wait_req", 32'(imem_req), 32'd1);
            check_eq("wait_pc", pc, m_pc);
            check_eq("wait_addr", imem_addr, m_pc);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        m_instr = word;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        check_eq("issue_valid", 32'(instr_valid), 32'd1);
        check_eq("issue_instr", instr, m_instr);
        check_eq("issue_req", 32'(imem_req), 32'd0);
        check_eq("issue_err", 32'(fetch_err), 32'd0);
        check_eq("issue_pc", pc, m_pc);
    endtask

    // Stalled cycles with redirect noise; nothing may move.
    task automatic do_stalls(input int n);
        for (int i = 0; i < n; i++) begin
            rand_redirect();
            halt = 1'($urandom);
            stall = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_eq("stall_instr", instr, m_instr);
            check_eq("stall_valid", 32'(instr_valid), 32'd1);
            check_eq("stall_pc", pc, m_pc);
            check_eq("stall_req", 32'(imem_req), 32'd0);
        end
        clear_inputs();
    endtask

    // Accept with whatever redirect inputs the caller has set up.
    task automatic accept();
        stall = 1'b0;
        model_accept();
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        check_eq("acc_pc", pc, m_pc);
        check_eq("acc_epc", epc, m_epc);
        check_eq("acc_valid", 32'(instr_valid), 32'd0);
        check_eq("acc_req", 32'(imem_req), m_halted ? 32'd0 : 32'd1);
    endtask

    task automatic check_halted(input int n);
        logic [31:0] hold;
        hold = m_pc;
        for (int i = 0; i < n; i++) begin
            rand_redirect();
            stall = 1'($urandom);
            imem_ack = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_eq("halt_req", 32'(imem_req), 32'd0);
            check_eq("halt_valid", 32'(instr_valid), 32'd0);
            check_eq("halt_pc", pc, hold);
        end
        imem_ack = 1'b0;
        clear_inputs();
    endtask

    // With delay slots, run the slot instruction so the redirect lands.
    task automatic settle_slot();
`ifdef BRANCH_DELAY_SLOT_EN
        fetch(0, $urandom);
        accept();
`endif
    endtask

    task automatic go_to(input logic [31:0] a);
        fetch(0, $urandom);
        jr = 1'b1; jr_target = a;
        accept();
        settle_slot();
        check_eq("goto_pc", pc, a);
    endtask

    int r, d;

    initial begin
        @(negedge clk);
        do_reset();

        // Sequential fetch with one-cycle ack latency.
        for (int i = 0; i < 4; i++) begin
            check_eq("seq_pc", pc, 32'(i * 4));
            fetch(1, $urandom);
            accept();
        end
        check_eq("seq_pc_end", pc, 32'h10);

        // Branch back by two words from 0x10.
        fetch(0, $urandom);
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
        accept();
        settle_slot();
        check_eq("branch_pc", pc, 32'h0000_000C);

        // Jump within the 256MB region.
        go_to(32'h1000_0020);
        fetch(0, $urandom);
        jump = 1'b1; jump_index = 26'h40;
        accept();
        settle_slot();
        check_eq("jump_pc", pc, 32'h1000_0100);

        // Misaligned jr raises the exception.
        go_to(32'h0000_0040);
        fetch(0, $urandom);
        jr = 1'b1; jr_target = 32'h0000_0202;
        accept();
        check_eq("jrbad_pc", pc, EV);
        check_eq("jrbad_epc", epc, 32'h40);

        // exc beats a simultaneous jump.
        go_to(32'h0000_0050);
        fetch(0, $urandom);
        exc = 1'b1; jump = 1'b1; jump_index = 26'h123;
        accept();
        check_eq("exc_pc", pc, EV);
        check_eq("exc_epc", epc, 32'h50);

        // Fetch timeout at 0x24, then ack just inside the window.
        go_to(32'h0000_0024);
        fetch(AT, $urandom);
        check_eq("to_epc", epc, 32'h24);
        check_eq("to_pc", pc, EV);
        accept();
        fetch(AT - 1, $urandom);
        check_eq("late_ack_epc", epc, 32'h24);
        accept();

        // Stalls with toggling redirects; only the accept cycle counts.
        fetch(0, $urandom);
        do_stalls(5);
        accept();

        // halt at 0x8.
        do_reset();
        fetch(0, $urandom); accept();
        fetch(0, $urandom); accept();
        fetch(0, $urandom);
        halt = 1'b1;
        accept();
        check_eq("halt_next_pc", pc, 32'h0000_000C);
        check_halted(30);
        do_reset();

`ifdef BRANCH_DELAY_SLOT_EN
        // Branch at 0x20 to 0x100 goes through the slot at 0x24.
        go_to(32'h0000_0020);
        fetch(0, $urandom);
        branch_taken = 1'b1; branch_offset = 32'h37;
        accept();
        check_eq("ds_slot_pc", pc, 32'h24);
        fetch(0, $urandom);
        jump = 1'b1; jump_index = 26'h3FF;
        accept();
        check_eq("ds_target_pc", pc, 32'h100);

        // exc in the slot reports the branch PC.
        go_to(32'h0000_0020);
        fetch(0, $urandom);
        branch_taken = 1'b1; branch_offset = 32'h37;
        accept();
        fetch(0, $urandom);
        exc = 1'b1;
        accept();
        check_eq("ds_exc_epc", epc, 32'h20);
        check_eq("ds_exc_pc", pc, EV);

        // Reset drops the pending target.
        go_to(32'h0000_0020);
        fetch(0, $urandom);
        branch_taken = 1'b1; branch_offset = 32'h37;
        accept();
        do_reset();
        fetch(0, $urandom); accept();
        fetch(0, $urandom); accept();
        check_eq("ds_rst_pc", pc, 32'h8);
`endif

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 9) == 0) d = int'($urandom_range(AT - 2, AT + 2));
                else                           d = int'($urandom_range(0, 3));
                fetch(d, $urandom);
                if ($urandom_range(0, 49) == 0) begin
                    do_reset();
                end else begin
                    do_stalls(int'($urandom_range(0, 3)));
                    rand_redirect();
                    halt = ($urandom_range(0, 29) == 0);
                    accept();
                    if (m_halted) begin
                        check_halted(10);
                        do_reset();
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
